// File: rtl/pc_sequencer_if.sv
// Bus between the program-counter stage and its controller/fetch neighbour.
// The controller side (master) drives requests; the sequencer (slave) drives
// the fetch address and status.
interface pc_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int OFF_W  = 16
);
  logic              start;
  logic              stall;
  logic              halt_req;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic              branch_taken;
  logic [OFF_W-1:0]  branch_offset;
  logic [ADDR_W-1:0] instruction_address;
  logic              addr_valid;
  logic [ADDR_W-1:0] pc_plus1;
  logic              wrap;
  logic              pending_lost;
  logic [1:0]        state;

  modport master (
    output start, stall, halt_req, jump, jump_target, branch_taken, branch_offset,
    input  instruction_address, addr_valid, pc_plus1, wrap, pending_lost, state
  );

  modport slave (
    input  start, stall, halt_req, jump, jump_target, branch_taken, branch_offset,
    output instruction_address, addr_valid, pc_plus1, wrap, pending_lost, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage feeding instruction fetch: sequential increment,
// absolute jump, PC-relative branch, stall with a one-entry redirect buffer,
// and a terminal halt. ADDR_W/OFF_W must match the connected interface.
module pc_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter int                OFF_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_pc, w_pc_next;
  logic              r_wrap, w_wrap_next;
  logic              r_lost, w_lost_next;
  logic              r_pend_valid, w_pend_valid_next;
  logic [ADDR_W-1:0] r_pend_target, w_pend_target_next;

  logic [ADDR_W-1:0] w_pc_plus1;
  logic [OFF_W-1:0]  w_branch_sum;
  logic              w_unused_branch_hi;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_redirect_target;

  // Branch target is PC+1 plus the signed offset; only the low ADDR_W bits
  // matter, so the sum is done at offset width and truncated.
  assign w_pc_plus1         = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign w_branch_sum       = {{(OFF_W-ADDR_W){1'b0}}, w_pc_plus1} + bus.branch_offset;
  assign w_unused_branch_hi = ^w_branch_sum[OFF_W-1:ADDR_W];
  assign w_redirect         = bus.jump | bus.branch_taken;
  assign w_redirect_target  = bus.jump ? bus.jump_target : w_branch_sum[ADDR_W-1:0];

  // Register all state; reset wins over everything, including a pending redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_wrap        <= 1'b0;
      r_lost        <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_wrap        <= w_wrap_next;
      r_lost        <= w_lost_next;
      r_pend_valid  <= w_pend_valid_next;
      r_pend_target <= w_pend_target_next;
    end
  end

  // Next-state and next-PC selection with priority halt > stall > jump > branch > increment.
  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_wrap_next        = 1'b0;
    w_lost_next        = r_lost;
    w_pend_valid_next  = r_pend_valid;
    w_pend_target_next = r_pend_target;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (bus.halt_req) begin
          w_state_next = S_HALT;
        end else if (bus.stall) begin
          // A redirect arriving with the stall is parked, not applied.
          w_state_next = S_STALL;
          if (w_redirect) begin
            if (r_pend_valid) w_lost_next = 1'b1;
            w_pend_valid_next  = 1'b1;
            w_pend_target_next = w_redirect_target;
          end
        end else if (w_redirect) begin
          w_pc_next = w_redirect_target;
        end else begin
          w_pc_next   = w_pc_plus1;
          w_wrap_next = (r_pc == {ADDR_W{1'b1}});
        end
      end
      S_STALL: begin
        if (bus.halt_req) begin
          w_state_next      = S_HALT;
          w_pend_valid_next = 1'b0;
        end else if (bus.stall) begin
          if (w_redirect) begin
            if (r_pend_valid) w_lost_next = 1'b1;
            w_pend_valid_next  = 1'b1;
            w_pend_target_next = w_redirect_target;
          end
        end else begin
          // Release: a fresh redirect beats the parked one; otherwise the
          // held word is re-presented rather than skipped.
          w_state_next      = S_RUN;
          w_pend_valid_next = 1'b0;
          if (w_redirect)        w_pc_next = w_redirect_target;
          else if (r_pend_valid) w_pc_next = r_pend_target;
        end
      end
      default: begin
        w_state_next = S_HALT;
      end
    endcase
  end

  assign bus.instruction_address = r_pc;
  assign bus.addr_valid          = (r_state == S_RUN);
  assign bus.pc_plus1            = w_pc_plus1;
  assign bus.wrap                = r_wrap;
  assign bus.pending_lost        = r_lost;
  assign bus.state               = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a queue-based reference model tracks the
// expected PC/state each cycle and is compared on every falling edge, with
// literal expectations at key points of each scenario.
module tb_pc_sequencer;
  localparam int ADDR_W = 8;
  localparam int OFF_W  = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;
  int   cyc_no;
  bit   chk_en;

  // reference model
  int   m_pc;
  int   m_state;   // 0 idle, 1 run, 2 stall, 3 halt
  int   m_pend[$];
  bit   m_lost;
  bit   m_wrap;

  pc_sequencer_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) bus ();

  pc_sequencer #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .RESET_PC(8'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc_no);
    end
  endtask

  function automatic int wrapmod(input int x);
    return ((x % DEPTH) + DEPTH) % DEPTH;
  endfunction

  task automatic model_step();
    int  tgt;
    int  off;
    bit  redir;
    m_wrap = 1'b0;
    if (reset) begin
      m_state = 0;
      m_pc    = 0;
      m_lost  = 1'b0;
      m_pend.delete();
    end else begin
      off   = $signed(bus.branch_offset);
      redir = bus.jump || bus.branch_taken;
      tgt   = bus.jump ? int'(bus.jump_target) : wrapmod(m_pc + 1 + off);
      case (m_state)
        0: if (bus.start) m_state = 1;
        1: begin
          if (bus.halt_req) m_state = 3;
          else if (bus.stall) begin
            m_state = 2;
            if (redir) begin
              if (m_pend.size() != 0) m_lost = 1'b1;
              m_pend.delete();
              m_pend.push_back(tgt);
            end
          end else if (redir) m_pc = tgt;
          else begin
            m_pc = m_pc + 1;
            if (m_pc == DEPTH) begin
              m_pc   = 0;
              m_wrap = 1'b1;
            end
          end
        end
        2: begin
          if (bus.halt_req) begin
            m_state = 3;
            m_pend.delete();
          end else if (bus.stall) begin
            if (redir) begin
              if (m_pend.size() != 0) m_lost = 1'b1;
              m_pend.delete();
              m_pend.push_back(tgt);
            end
          end else begin
            m_state = 1;
            if (redir) m_pc = tgt;
            else if (m_pend.size() != 0) m_pc = m_pend[0];
            m_pend.delete();
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic clr();
    reset             = 1'b0;
    bus.start         = 1'b0;
    bus.stall         = 1'b0;
    bus.halt_req      = 1'b0;
    bus.jump          = 1'b0;
    bus.jump_target   = '0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = '0;
  endtask

  // One clock with the currently applied inputs; returns after the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cyc_no++;
      check("addr",         int'(bus.instruction_address), m_pc);
      check("pc_plus1",     int'(bus.pc_plus1),            wrapmod(m_pc + 1));
      check("addr_valid",   int'(bus.addr_valid),          int'(m_state == 1));
      check("wrap",         int'(bus.wrap),                int'(m_wrap));
      check("pending_lost", int'(bus.pending_lost),        int'(m_lost));
      check("state",        int'(bus.state),               m_state);
      $display("cyc %0d: state=%0d addr=%0d valid=%0d wrap=%0d lost=%0d",
               cyc_no, bus.state, bus.instruction_address, bus.addr_valid,
               bus.wrap, bus.pending_lost);
    end
  end

  initial begin
    n_checks = 0;
    n_err    = 0;
    cyc_no   = 0;
    m_pc     = 0;
    m_state  = 0;
    m_lost   = 0;
    m_wrap   = 0;
    clr();
    reset  = 1'b1;
    chk_en = 1'b1;
    tick();
    tick();
    check("rst_state", int'(bus.state), 0);
    check("rst_addr",  int'(bus.instruction_address), 0);
    check("rst_valid", int'(bus.addr_valid), 0);

    // 1: start then free-run 0,1,2,3
    clr(); bus.start = 1'b1; tick();
    check("t1_addr0", int'(bus.instruction_address), 0);
    check("t1_valid", int'(bus.addr_valid), 1);
    clr(); tick(); check("t1_addr1", int'(bus.instruction_address), 1);
    tick();        check("t1_addr2", int'(bus.instruction_address), 2);
    tick();        check("t1_addr3", int'(bus.instruction_address), 3);

    // 2: sequential wrap 254,255,0
    clr(); bus.jump = 1'b1; bus.jump_target = 8'd254; tick();
    check("t2_addr254", int'(bus.instruction_address), 254);
    clr(); tick();
    check("t2_addr255", int'(bus.instruction_address), 255);
    check("t2_nowrap",  int'(bus.wrap), 0);
    tick();
    check("t2_addr0", int'(bus.instruction_address), 0);
    check("t2_wrap",  int'(bus.wrap), 1);
    tick();
    check("t2_wrap_clr", int'(bus.wrap), 0);

    // 3: relative branches from 10
    clr(); bus.jump = 1'b1; bus.jump_target = 8'd10; tick();
    clr(); bus.branch_taken = 1'b1; bus.branch_offset = 16'hFFFB; tick();
    check("t3_back", int'(bus.instruction_address), 6);
    clr(); bus.jump = 1'b1; bus.jump_target = 8'd10; tick();
    clr(); bus.branch_taken = 1'b1; bus.branch_offset = 16'h0102; tick();
    check("t3_fwd", int'(bus.instruction_address), 13);

    // 4: stall with two buffered redirects, second overwrites first
    clr(); bus.jump = 1'b1; bus.jump_target = 8'd20; tick();
    clr(); bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_target = 8'd40; tick();
    check("t4_hold",  int'(bus.instruction_address), 20);
    check("t4_state", int'(bus.state), 2);
    clr(); bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_offset = 16'd1; tick();
    check("t4_lost", int'(bus.pending_lost), 1);
    clr(); bus.stall = 1'b1; tick();
    check("t4_hold2", int'(bus.instruction_address), 20);
    clr(); tick();
    check("t4_release", int'(bus.instruction_address), 22);
    // stall with nothing buffered re-presents the held word
    clr(); bus.jump = 1'b1; bus.jump_target = 8'd50; tick();
    clr(); bus.stall = 1'b1; tick();
    clr(); tick();
    check("t4_heldword", int'(bus.instruction_address), 50);
    tick();
    check("t4_after", int'(bus.instruction_address), 51);
    // redirect in the release cycle beats the buffered entry
    clr(); bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_target = 8'd99; tick();
    clr(); bus.jump = 1'b1; bus.jump_target = 8'd7; tick();
    check("t4_override", int'(bus.instruction_address), 7);

    // 5: jump beats branch; jump to 0 does not wrap; halt beats stall
    clr(); bus.jump = 1'b1; bus.jump_target = 8'h80;
    bus.branch_taken = 1'b1; bus.branch_offset = 16'd5; tick();
    check("t5_jump_wins", int'(bus.instruction_address), 128);
    clr(); bus.jump = 1'b1; bus.jump_target = 8'd0; tick();
    check("t5_jump0_nowrap", int'(bus.wrap), 0);
    clr(); bus.halt_req = 1'b1; bus.stall = 1'b1; tick();
    check("t5_halt", int'(bus.state), 3);
    clr(); bus.start = 1'b1; bus.jump = 1'b1; bus.jump_target = 8'd33; tick();
    check("t5_halt_stuck", int'(bus.state), 3);
    check("t5_halt_pc",    int'(bus.instruction_address), 0);

    // 6: reset mid-stall with a pending entry
    clr(); reset = 1'b1; tick();
    clr(); bus.start = 1'b1; tick();
    clr(); bus.jump = 1'b1; bus.jump_target = 8'd20; tick();
    clr(); bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_target = 8'd40; tick();
    clr(); bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_target = 8'd60; tick();
    clr(); bus.stall = 1'b1; reset = 1'b1; tick();
    check("t6_idle", int'(bus.state), 0);
    check("t6_pc",   int'(bus.instruction_address), 0);
    check("t6_lost", int'(bus.pending_lost), 0);
    clr(); bus.start = 1'b1; tick();
    clr(); tick();
    clr(); bus.stall = 1'b1; tick();
    clr(); tick();
    check("t6_empty_buf", int'(bus.instruction_address), 1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
